// File: rtl/elevator_pkg.sv
// Shared floor constants and helpers for the elevator call panel and controller.
package elevator_pkg;

    localparam int unsigned N_FLOORS = 5;
    localparam int unsigned FLOOR_W  = 3;

    typedef logic [FLOOR_W-1:0] floor_t;

    // One-hot floor decode; codes at or above N_FLOORS decode to no floor.
    function automatic logic [N_FLOORS-1:0] floor_onehot(input floor_t f);
        floor_onehot = '0;
        for (int k = 0; k < N_FLOORS; k++) begin
            if (f == floor_t'(k)) floor_onehot[k] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/call_panel_debounce.sv
// One-bit 2-flop synchronizer followed by a stable-time debounce filter.
// Filter is built only when ELEVATOR_CALL_PANEL_DEBOUNCE_EN is defined.
module call_panel_debounce #(
    parameter int unsigned DB_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);

    logic [1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync_q <= '0;
        else       sync_q <= {sync_q[0], i_raw};
    end

`ifdef ELEVATOR_CALL_PANEL_DEBOUNCE_EN
    // Counter runs 0..DB_CYCLES-1; the level flips on the DB_CYCLES-th differing cycle.
    localparam int unsigned CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) level_d = sync_q[1];
            else                             cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
`else
    assign o_level = sync_q[1];
`endif

endmodule

// File: rtl/elevator_call_panel.sv
// Button panel: synchronize/filter 11 buttons, latch floor calls, clear on door-open at floor.
// Optional debounce via macro ELEVATOR_CALL_PANEL_DEBOUNCE_EN.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DEBOUNCE_MS  = 10,
    parameter int unsigned REARM_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_btn_ext,
    input  logic [4:0] i_btn_inter,
    input  logic       i_btn_stop,
    input  logic [2:0] i_current_floor,
    input  logic       i_door,
    output logic [4:0] o_req_ext,
    output logic [4:0] o_req_inter,
    output logic       o_stop,
    output logic [4:0] o_lamp_ext,
    output logic [4:0] o_lamp_inter
);

    localparam int unsigned DB_RAW    = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int unsigned N_BTN     = 2 * N_FLOORS;
    localparam int unsigned RW        = (REARM_CYCLES < 1) ? 1 : $clog2(REARM_CYCLES + 1);

    // Bit order everywhere: [4:0] hall, [9:5] cab, [10] stop.
    logic [N_BTN:0]     raw;
    logic [N_BTN:0]     filt;
    logic [N_BTN-1:0]   filt_prev_q;
    logic [N_BTN-1:0]   latch_q, latch_d;
    logic [N_BTN-1:0]   rise, clr, ready;
    logic [N_FLOORS-1:0] clr_floor;
    logic [RW-1:0]      rearm_q [N_BTN];
    logic [RW-1:0]      rearm_d [N_BTN];

    assign raw = {i_btn_stop, i_btn_inter, i_btn_ext};

    for (genvar g = 0; g <= N_BTN; g++) begin : g_btn
        call_panel_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_raw  (raw[g]),
            .o_level(filt[g])
        );
    end

    always_comb begin
        clr_floor = i_door ? floor_onehot(floor_t'(i_current_floor)) : '0;
        clr       = {clr_floor, clr_floor};
        rise      = filt[N_BTN-1:0] & ~filt_prev_q;
        // Clear wins over a same-cycle press.
        latch_d   = (latch_q | rise) & ~clr;
        for (int i = 0; i < N_BTN; i++) begin
            ready[i] = (rearm_q[i] == '0);
            if (clr[i])         rearm_d[i] = RW'(REARM_CYCLES);
            else if (!ready[i]) rearm_d[i] = rearm_q[i] - 1'b1;
            else                rearm_d[i] = rearm_q[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            filt_prev_q <= '0;
            latch_q     <= '0;
            for (int i = 0; i < N_BTN; i++) rearm_q[i] <= '0;
        end else begin
            filt_prev_q <= filt[N_BTN-1:0];
            latch_q     <= latch_d;
            for (int i = 0; i < N_BTN; i++) rearm_q[i] <= rearm_d[i];
        end
    end

    assign o_lamp_ext   = latch_q[4:0];
    assign o_lamp_inter = latch_q[9:5];
    assign o_req_ext    = latch_q[4:0] & ready[4:0];
    assign o_req_inter  = latch_q[9:5] & ready[9:5];
    assign o_stop       = filt[N_BTN];

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel (CLK_HZ=1000, DEBOUNCE_MS=4, REARM_CYCLES=2).
module tb_elevator_call_panel;

`ifdef ELEVATOR_CALL_PANEL_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = 7;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_ext = '0;
    logic [4:0] btn_inter = '0;
    logic       btn_stop = 1'b0;
    logic [2:0] cur_floor = '0;
    logic       door = 1'b0;
    logic [4:0] req_ext, req_inter, lamp_ext, lamp_inter;
    logic       stop;

    int checks = 0;
    int failures = 0;

    elevator_call_panel #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .REARM_CYCLES(2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_btn_ext      (btn_ext),
        .i_btn_inter    (btn_inter),
        .i_btn_stop     (btn_stop),
        .i_current_floor(cur_floor),
        .i_door         (door),
        .o_req_ext      (req_ext),
        .o_req_inter    (req_inter),
        .o_stop         (stop),
        .o_lamp_ext     (lamp_ext),
        .o_lamp_inter   (lamp_inter)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({req_ext, req_inter, lamp_ext, lamp_inter, stop} !== 21'd0) begin
            $display("FAIL reset_outputs got=%h want=0", {req_ext, req_inter, lamp_ext, lamp_inter, stop});
            failures++;
        end
        rst = 1'b0;
        step(LAT + 2);
        checks++;
        if ({req_ext, req_inter, lamp_ext, lamp_inter, stop} !== 21'd0) begin
            $display("FAIL idle_after_reset got=%h want=0", {req_ext, req_inter, lamp_ext, lamp_inter, stop});
            failures++;
        end
    endtask

    task automatic test_stop();
        btn_stop = 1'b1;
        step(LAT - 2);
        checks++;
        if (stop !== 1'b0) begin
            $display("FAIL stop_early got=%b want=0", stop);
            failures++;
        end
        step(1);
        checks++;
        if (stop !== 1'b1) begin
            $display("FAIL stop_level got=%b want=1", stop);
            failures++;
        end
        checks++;
        if ({req_ext, req_inter} !== 10'd0) begin
            $display("FAIL stop_no_req got=%h want=0", {req_ext, req_inter});
            failures++;
        end
        btn_stop = 1'b0;
        step(LAT + 2);
        checks++;
        if (stop !== 1'b0) begin
            $display("FAIL stop_release got=%b want=0", stop);
            failures++;
        end
    endtask

    task automatic test_hold();
        btn_inter[3] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            checks++;
            if (req_inter[3] !== (i >= LAT) || lamp_inter[3] !== (i >= LAT)) begin
                $display("FAIL hold_inter3 cyc=%0d got req=%b lamp=%b want=%b",
                         i, req_inter[3], lamp_inter[3], (i >= LAT));
                failures++;
            end
        end
        btn_inter[3] = 1'b0;
        step(LAT + 2);
    endtask

    task automatic test_glitch();
        int n = 0;
        for (int p = 0; p < 4; p++) begin
            for (int h = 0; h < 2; h++) begin
                btn_ext[1] = (h == 0);
                for (int c = 0; c < 3; c++) begin
                    step(1);
                    n++;
                    checks++;
                    if (req_ext[1] !== (DEB ? 1'b0 : (n >= 3))) begin
                        $display("FAIL glitch_ext1 cyc=%0d got=%b want=%b",
                                 n, req_ext[1], (DEB ? 1'b0 : (n >= 3)));
                        failures++;
                    end
                end
            end
        end
        step(LAT + 2);
    endtask

    task automatic test_clear();
        btn_ext[2] = 1'b1;
        btn_ext[4] = 1'b1;
        btn_inter[2] = 1'b1;
        step(LAT - 1);
        checks++;
        if (lamp_ext[2] !== 1'b0) begin
            $display("FAIL multi_early got=%b want=0", lamp_ext[2]);
            failures++;
        end
        step(1);
        checks++;
        if ({lamp_ext[4], lamp_ext[2], lamp_inter[2], req_ext[4], req_ext[2], req_inter[2]} !== 6'b111111) begin
            $display("FAIL multi_latch got=%b want=111111",
                     {lamp_ext[4], lamp_ext[2], lamp_inter[2], req_ext[4], req_ext[2], req_inter[2]});
            failures++;
        end
        btn_ext = '0;
        btn_inter = '0;
        step(LAT + 2);
        door = 1'b1;
        cur_floor = 3'd2;
        step(1);
        door = 1'b0;
        checks++;
        if ({lamp_ext[2], lamp_inter[2], req_ext[2], req_inter[2]} !== 4'b0000) begin
            $display("FAIL clear_floor2 got=%b want=0000",
                     {lamp_ext[2], lamp_inter[2], req_ext[2], req_inter[2]});
            failures++;
        end
        checks++;
        if ({lamp_ext[4], req_ext[4], lamp_inter[3], req_inter[3]} !== 4'b1111) begin
            $display("FAIL clear_others got=%b want=1111",
                     {lamp_ext[4], req_ext[4], lamp_inter[3], req_inter[3]});
            failures++;
        end
    endtask

    task automatic test_priority();
        // Filtered edge coincides with the clear.
        btn_inter[0] = 1'b1;
        step(LAT - 1);
        door = 1'b1;
        cur_floor = 3'd0;
        step(1);
        door = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lamp_inter[0] !== 1'b0 || req_inter[0] !== 1'b0) begin
                $display("FAIL prio_clear_wins cyc=%0d got lamp=%b req=%b want 0",
                         i, lamp_inter[0], req_inter[0]);
                failures++;
            end
            step(1);
        end
        btn_inter[0] = 1'b0;
        step(LAT + 2);
        // Latch cab 0, then press again with the edge one cycle after a clear.
        btn_inter[0] = 1'b1;
        step(LAT);
        btn_inter[0] = 1'b0;
        checks++;
        if (lamp_inter[0] !== 1'b1 || req_inter[0] !== 1'b1) begin
            $display("FAIL prio_preset got lamp=%b req=%b want 1", lamp_inter[0], req_inter[0]);
            failures++;
        end
        step(LAT + 2);
        btn_inter[0] = 1'b1;
        step(LAT - 2);
        door = 1'b1;
        step(1);
        door = 1'b0;
        checks++;
        if (lamp_inter[0] !== 1'b0 || req_inter[0] !== 1'b0) begin
            $display("FAIL rearm_cleared got lamp=%b req=%b want 0", lamp_inter[0], req_inter[0]);
            failures++;
        end
        step(1);
        checks++;
        if (lamp_inter[0] !== 1'b1 || req_inter[0] !== 1'b0) begin
            $display("FAIL rearm_hold got lamp=%b req=%b want lamp=1 req=0",
                     lamp_inter[0], req_inter[0]);
            failures++;
        end
        step(1);
        checks++;
        if (lamp_inter[0] !== 1'b1 || req_inter[0] !== 1'b1) begin
            $display("FAIL rearm_expire got lamp=%b req=%b want 1", lamp_inter[0], req_inter[0]);
            failures++;
        end
        btn_inter[0] = 1'b0;
        step(LAT + 2);
    endtask

    task automatic test_ignore();
        btn_ext = 5'h1f;
        btn_inter = 5'h1f;
        step(LAT);
        btn_ext = '0;
        btn_inter = '0;
        checks++;
        if ({lamp_ext, lamp_inter, req_ext, req_inter} !== 20'hfffff) begin
            $display("FAIL all_latched got=%h want=fffff", {lamp_ext, lamp_inter, req_ext, req_inter});
            failures++;
        end
        step(LAT + 2);
        door = 1'b1;
        for (int f = 5; f <= 7; f++) begin
            cur_floor = 3'(f);
            step(1);
            checks++;
            if ({lamp_ext, lamp_inter, req_ext, req_inter} !== 20'hfffff) begin
                $display("FAIL bad_floor_%0d got=%h want=fffff",
                         f, {lamp_ext, lamp_inter, req_ext, req_inter});
                failures++;
            end
        end
        door = 1'b0;
    endtask

    task automatic test_reset_mid();
        door = 1'b1;
        for (int f = 0; f < 3; f++) begin
            cur_floor = 3'(f);
            step(1);
        end
        door = 1'b0;
        step(1);
        checks++;
        if ({lamp_ext, lamp_inter} !== 10'b11000_11000) begin
            $display("FAIL four_latched got=%b want=1100011000", {lamp_ext, lamp_inter});
            failures++;
        end
        btn_inter[3] = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ext, req_inter, lamp_ext, lamp_inter, stop} !== 21'd0) begin
            $display("FAIL async_reset got=%h want=0", {req_ext, req_inter, lamp_ext, lamp_inter, stop});
            failures++;
        end
        step(1);
        rst = 1'b0;
        step(LAT - 1);
        checks++;
        if (req_inter !== 5'd0) begin
            $display("FAIL rerequest_early got=%b want=00000", req_inter);
            failures++;
        end
        step(1);
        checks++;
        if (req_inter !== 5'b01000 || lamp_inter !== 5'b01000) begin
            $display("FAIL rerequest got req=%b lamp=%b want 01000", req_inter, lamp_inter);
            failures++;
        end
        checks++;
        if ({lamp_ext, req_ext} !== 10'd0) begin
            $display("FAIL no_replay got=%b want=0", {lamp_ext, req_ext});
            failures++;
        end
        btn_inter[3] = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_stop();
        test_hold();
        test_glitch();
        test_clear();
        test_priority();
        test_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
